// File: rtl/arb_pkg.sv
// Shared definitions for the tree arbiter and its leaf-side requesters.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package arb_pkg;

    // Default width of the wait/hold counters in requester adapters.
    localparam int ARB_CW = 8;

    // Four-phase request protocol seen by a leaf arbitration cell.
    // The encoding is shared with the cell and processor models; do not reorder.
    typedef enum logic [1:0] {
        PH_IDLE    = 2'd0,
        PH_REQUEST = 2'd1,
        PH_LOCK    = 2'd2,
        PH_RELEASE = 2'd3
    } phase_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Latency: count updates one cycle after clr/inc are sampled.
// Backpressure: none; inc is ignored once the counter holds all-ones.
//
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   clr      : clear to zero (wins over inc)
//   inc      : increment by one, saturating at 2^W-1
//   cnt      : current count
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/arb_client_port.sv
// Leaf-side requester: turns a client level request/done into the idle/request/lock/release phases.
// Latency: ack sampled at edge t gives req=lock and cli_grant=1 from cycle t+1; release lasts one cycle.
// Backpressure: a request is sticky until the leaf cell acks; new requests are held off by the idle gap.
//
// Ports:
//   clk, rst  : clock and synchronous active-high reset
//   ack       : acknowledge from the leaf arbitration cell (only looked at in request)
//   cli_req   : client wants the resource (level)
//   cli_done  : client finished (only looked at in lock)
//   req       : four-phase request to the leaf cell; also the state register
//   cli_grant : client owns the resource (req == lock)
//   starved   : client has waited STARVE_LIMIT or more cycles in request
//   last_wait : cycles spent in request by the most recently granted request
//   timeout   : one-cycle pulse aligned with a forced release
//
// Build option: define ARB_HOLD_TIMEOUT_EN to force release after MAX_HOLD lock
// cycles; without it there is no hold limit and timeout is tied low.
module arb_client_port
    import arb_pkg::*;
#(
    parameter int CW           = ARB_CW,
    parameter int MIN_GAP      = 1,
    parameter int STARVE_LIMIT = 64,
    parameter int MAX_HOLD     = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ack,
    input  logic          cli_req,
    input  logic          cli_done,
    output phase_t        req,
    output logic          cli_grant,
    output logic          starved,
    output logic [CW-1:0] last_wait,
    output logic          timeout
);

    localparam int GW = (MIN_GAP > 1) ? $clog2(MIN_GAP + 1) : 1;
    localparam logic [CW-1:0] STARVE_AT = CW'(STARVE_LIMIT);

    // Elaboration-time parameter sanity checks.
    if (MAX_HOLD < 1) begin : g_bad_max_hold
        $error("arb_client_port: MAX_HOLD must be at least 1");
    end
    if (MIN_GAP < 0) begin : g_bad_min_gap
        $error("arb_client_port: MIN_GAP must not be negative");
    end

    phase_t        req_nxt;
    logic          timeout_nxt;
    logic [CW-1:0] wait_cnt;
    logic [CW-1:0] hold_cnt;
    logic [GW-1:0] gap_cnt;
    logic          hold_expired;

    // wait_cnt is kept at zero outside request, so every request starts
    // counting from zero and starved falls as soon as the state moves on.
    sat_counter #(.W(CW)) u_wait_cnt (
        .clk (clk),
        .rst (rst),
        .clr (req != PH_REQUEST),
        .inc (req == PH_REQUEST),
        .cnt (wait_cnt)
    );

    // hold_cnt counts lock cycles and is cleared on the way out of release.
    sat_counter #(.W(CW)) u_hold_cnt (
        .clk (clk),
        .rst (rst),
        .clr (req == PH_RELEASE),
        .inc (req == PH_LOCK),
        .cnt (hold_cnt)
    );

`ifdef ARB_HOLD_TIMEOUT_EN
    // hold_cnt is 0 on the first lock cycle, so MAX_HOLD-1 marks the last one.
    assign hold_expired = (hold_cnt == CW'(MAX_HOLD - 1));
`else
    logic unused_hold;
    assign unused_hold  = ^hold_cnt;
    assign hold_expired = 1'b0;
`endif

    always_comb begin
        req_nxt     = req;
        timeout_nxt = 1'b0;
        unique case (req)
            PH_IDLE: begin
                if ((gap_cnt == '0) && cli_req) begin
                    req_nxt = PH_REQUEST;
                end
            end
            PH_REQUEST: begin
                // cli_req is deliberately ignored: withdrawing after the cell
                // has granted would strand the token in the tree.
                if (ack) begin
                    req_nxt = PH_LOCK;
                end
            end
            PH_LOCK: begin
                if (cli_done || !cli_req) begin
                    req_nxt = PH_RELEASE;
                end else if (hold_expired) begin
                    req_nxt     = PH_RELEASE;
                    timeout_nxt = 1'b1;
                end
            end
            PH_RELEASE: begin
                req_nxt = PH_IDLE;
            end
            default: begin
                req_nxt = PH_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req     <= PH_IDLE;
            timeout <= 1'b0;
        end else begin
            req     <= req_nxt;
            timeout <= timeout_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_wait <= '0;
        end else if ((req == PH_REQUEST) && ack) begin
            last_wait <= wait_cnt;
        end
    end

    // Gap counter is loaded while in release, so the forced idle cycles are
    // in addition to the single idle cycle every release is followed by.
    always_ff @(posedge clk) begin
        if (rst) begin
            gap_cnt <= '0;
        end else if (req == PH_RELEASE) begin
            gap_cnt <= GW'(MIN_GAP);
        end else if ((req == PH_IDLE) && (gap_cnt != '0)) begin
            gap_cnt <= gap_cnt - GW'(1);
        end
    end

    assign cli_grant = (req == PH_LOCK);
    assign starved   = (req == PH_REQUEST) && (wait_cnt >= STARVE_AT);

endmodule

// File: tb/tb_arb_client_port.sv
// Directed bench for arb_client_port with CW=8, MIN_GAP=1, STARVE_LIMIT=64, MAX_HOLD=4.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Define ARB_HOLD_TIMEOUT_EN for both bench and RTL to exercise the hold limit.
module tb_arb_client_port;
    import arb_pkg::*;

    logic       clk;
    logic       rst;
    logic       ack;
    logic       cli_req;
    logic       cli_done;
    phase_t     req;
    logic       cli_grant;
    logic       starved;
    logic [7:0] last_wait;
    logic       timeout;

    int n_vec;
    int n_miss;

    arb_client_port #(
        .CW           (8),
        .MIN_GAP      (1),
        .STARVE_LIMIT (64),
        .MAX_HOLD     (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ack       (ack),
        .cli_req   (cli_req),
        .cli_done  (cli_done),
        .req       (req),
        .cli_grant (cli_grant),
        .starved   (starved),
        .last_wait (last_wait),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, want %0d", tag, got, exp);
        end
    endtask

    task automatic chk_phase(input string tag, input phase_t exp);
        chk(tag, 32'(req), 32'(exp));
        chk({tag, "_grant"}, 32'(cli_grant), 32'(exp == PH_LOCK));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by time %0t, want finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec    = 0;
        n_miss   = 0;
        rst      = 1'b1;
        ack      = 1'b0;
        cli_req  = 1'b0;
        cli_done = 1'b0;
        tick(3);

        // Reset state.
        chk_phase("rst_req", PH_IDLE);
        chk("rst_starved", 32'(starved), 0);
        chk("rst_last_wait", 32'(last_wait), 0);
        chk("rst_timeout", 32'(timeout), 0);
        chk("rst_wait_cnt", 32'(dut.wait_cnt), 0);
        chk("rst_hold_cnt", 32'(dut.hold_cnt), 0);
        chk("rst_gap_cnt", 32'(dut.gap_cnt), 0);

        // Long wait with no ack: starvation threshold and saturation.
        rst     = 1'b0;
        cli_req = 1'b1;
        tick(1);
        chk_phase("req_cycle1", PH_REQUEST);
        chk("wait_start", 32'(dut.wait_cnt), 0);
        tick(63);
        chk("wait_63", 32'(dut.wait_cnt), 63);
        chk("starved_63", 32'(starved), 0);
        tick(1);
        chk("wait_64", 32'(dut.wait_cnt), 64);
        chk("starved_64", 32'(starved), 1);
        tick(6);
        chk("wait_70", 32'(dut.wait_cnt), 70);
        chk_phase("req_70", PH_REQUEST);
        tick(185);
        chk("wait_255", 32'(dut.wait_cnt), 255);
        tick(5);
        chk("wait_sat", 32'(dut.wait_cnt), 255);
        chk("starved_sat", 32'(starved), 1);

        // Grant from saturated wait, then done -> release -> gap -> request.
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        chk_phase("lock_after_sat", PH_LOCK);
        chk("last_wait_sat", 32'(last_wait), 255);
        chk("starved_lock", 32'(starved), 0);
        cli_done = 1'b1;
        tick(1);
        cli_done = 1'b0;
        chk_phase("release_1", PH_RELEASE);
        tick(1);
        chk_phase("idle_gap_1", PH_IDLE);
        chk("gap_loaded", 32'(dut.gap_cnt), 1);
        chk("hold_cleared", 32'(dut.hold_cnt), 0);
        tick(1);
        chk_phase("idle_gap_0", PH_IDLE);
        tick(1);
        chk_phase("rerequest", PH_REQUEST);

        // Ack at wait=5; done two cycles into lock.
        tick(5);
        chk("wait_5", 32'(dut.wait_cnt), 5);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        chk_phase("lock_w5", PH_LOCK);
        chk("last_wait_5", 32'(last_wait), 5);
        tick(1);
        chk_phase("lock_w5_2", PH_LOCK);
        cli_done = 1'b1;
        tick(1);
        cli_done = 1'b0;
        chk_phase("release_w5", PH_RELEASE);
        tick(2);
        chk_phase("idle_w5", PH_IDLE);
        tick(1);
        chk_phase("request_w5", PH_REQUEST);

        // Withdrawn request stays sticky; cli_done outside lock is ignored.
        cli_req = 1'b0;
        tick(3);
        chk_phase("sticky_req", PH_REQUEST);
        cli_done = 1'b1;
        tick(1);
        cli_done = 1'b0;
        chk_phase("done_in_req", PH_REQUEST);
        chk("wait_4", 32'(dut.wait_cnt), 4);
        ack = 1'b1;
        tick(1);
        chk_phase("lock_dropped", PH_LOCK);
        chk("last_wait_4", 32'(last_wait), 4);
        // ack stays high through lock, release and idle.
        tick(1);
        chk_phase("release_dropped", PH_RELEASE);
        tick(1);
        chk_phase("idle_ack_a", PH_IDLE);
        tick(2);
        chk_phase("idle_ack_b", PH_IDLE);
        ack = 1'b0;

        // ack held during lock has no effect.
        cli_req = 1'b1;
        tick(1);
        chk_phase("request_again", PH_REQUEST);
        ack = 1'b1;
        tick(3);
        ack = 1'b0;
        chk_phase("lock_ack_held", PH_LOCK);
        chk("hold_2", 32'(dut.hold_cnt), 2);

`ifdef ARB_HOLD_TIMEOUT_EN
        // Forced release after 4 lock cycles.
        tick(1);
        chk_phase("lock_4th", PH_LOCK);
        chk("timeout_pre", 32'(timeout), 0);
        tick(1);
        chk_phase("release_to", PH_RELEASE);
        chk("timeout_pulse", 32'(timeout), 1);
        tick(1);
        chk_phase("idle_to", PH_IDLE);
        chk("timeout_drop", 32'(timeout), 0);
        tick(2);
        chk_phase("request_to", PH_REQUEST);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        tick(3);
        chk("hold_3", 32'(dut.hold_cnt), 3);
        cli_done = 1'b1;
        tick(1);
        cli_done = 1'b0;
        chk_phase("release_done4", PH_RELEASE);
        chk("timeout_done4", 32'(timeout), 0);
        tick(1);
`else
        // No hold limit: lock persists past 4 cycles.
        tick(2);
        chk_phase("lock_nolimit", PH_LOCK);
        chk("hold_4", 32'(dut.hold_cnt), 4);
        chk("timeout_off", 32'(timeout), 0);
        cli_done = 1'b1;
        tick(1);
        cli_done = 1'b0;
        chk_phase("release_nolimit", PH_RELEASE);
        tick(1);
`endif
        chk_phase("idle_pre_rst", PH_IDLE);

        // Reset while holding lock.
        tick(2);
        chk_phase("request_pre_rst", PH_REQUEST);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        tick(1);
        chk_phase("lock_pre_rst", PH_LOCK);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk_phase("rst_lock", PH_IDLE);
        chk("rst_lock_wait", 32'(dut.wait_cnt), 0);
        chk("rst_lock_hold", 32'(dut.hold_cnt), 0);
        chk("rst_lock_gap", 32'(dut.gap_cnt), 0);
        chk("rst_lock_last", 32'(last_wait), 0);
        tick(1);
        chk_phase("post_rst_req", PH_REQUEST);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
